// File: rtl/wb_stage_p.sv
// MIPS write-back stage with a MEM/WB pipeline register: result/destination muxing,
// sub-word load extraction, stall/flush control and a retired-instruction counter.
module wb_stage_p #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_dst_sel,
    input  logic              in_reg_write,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [1:0]        in_byte_off,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_misalign,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

    logic [31:0]       mem_w;
    logic              is_load;
    logic              is_word;
    logic              ld_misalign;
    logic [1:0]        eff_off;
    logic [15:0]       lane16;
    logic [7:0]        lane8;
    logic              sign16;
    logic              sign8;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] next_data;
    logic [REG_AW-1:0] next_addr;
    logic              next_we;
    logic              next_misalign;

    assign mem_w   = in_mem[31:0];
    assign is_load = (in_wb_sel == 2'b01);
    // The reserved load size behaves exactly like a word load, alignment included.
    assign is_word = (in_ld_size == 2'b00) || (in_ld_size == 2'b11);

    assign ld_misalign = is_load &&
                         (((in_ld_size == 2'b01) && in_byte_off[0]) ||
                          (is_word && (in_byte_off != 2'b00)));
    assign eff_off     = ld_misalign ? 2'b00 : in_byte_off;

    always_comb begin
        lane16   = mem_w[15:0];
        lane8    = mem_w[7:0];
        load_val = in_mem;
        if (eff_off[1]) begin
            lane16 = mem_w[31:16];
        end
        case (eff_off)
            2'b01:   lane8 = mem_w[15:8];
            2'b10:   lane8 = mem_w[23:16];
            2'b11:   lane8 = mem_w[31:24];
            default: lane8 = mem_w[7:0];
        endcase
        sign16 = lane16[15] & ~in_ld_unsigned;
        sign8  = lane8[7] & ~in_ld_unsigned;
        case (in_ld_size)
            2'b01:   load_val = {{(DATA_W-16){sign16}}, lane16};
            2'b10:   load_val = {{(DATA_W-8){sign8}}, lane8};
            default: load_val = in_mem;
        endcase
    end

    always_comb begin
        next_data = '0;
        next_addr = '0;
        case (in_wb_sel)
            2'b00:   next_data = in_alu;
            2'b01:   next_data = load_val;
            2'b10:   next_data = in_pc4;
            default: next_data = '0;
        endcase
        case (in_dst_sel)
            2'b00:   next_addr = in_rd;
            2'b01:   next_addr = in_rt;
            2'b10:   next_addr = LINK_ADDR;
            default: next_addr = '0;
        endcase
    end

    assign next_misalign = in_valid & ld_misalign;
    assign next_we       = in_valid & in_reg_write & (in_dst_sel != 2'b11) &
                           (next_addr != '0) & ~ld_misalign;

    // A stalled instruction has already retired once, so only its address/data are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_misalign <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            retired     <= '0;
        end else begin
            if (wb_valid) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                wb_valid    <= 1'b0;
                wb_we       <= 1'b0;
                wb_misalign <= 1'b0;
                wb_addr     <= '0;
                wb_data     <= '0;
            end else if (stall) begin
                wb_valid    <= 1'b0;
                wb_we       <= 1'b0;
                wb_misalign <= 1'b0;
            end else begin
                wb_valid    <= in_valid;
                wb_we       <= next_we;
                wb_misalign <= next_misalign;
                wb_addr     <= next_addr;
                wb_data     <= next_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_p.sv
// Scoreboard bench for wb_stage_p: directed vectors push expectations, a monitor pops
// and compares them; a second instance with a 3-bit counter exercises counter wrap.
module tb_wb_stage_p;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_alu, in_mem, in_pc4;
    logic [4:0]  in_rd, in_rt;
    logic [1:0]  in_wb_sel, in_dst_sel, in_ld_size, in_byte_off;
    logic        in_reg_write, in_ld_unsigned;

    logic        wb_valid, wb_we, wb_misalign;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retired;

    logic        s_valid, s_we, s_misalign;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [2:0]  s_retired;

    always #5 clk = ~clk;

    wb_stage_p u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4), .in_rd(in_rd), .in_rt(in_rt),
        .in_wb_sel(in_wb_sel), .in_dst_sel(in_dst_sel), .in_reg_write(in_reg_write),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_misalign(wb_misalign), .retired(retired)
    );

    wb_stage_p #(.CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4), .in_rd(in_rd), .in_rt(in_rt),
        .in_wb_sel(in_wb_sel), .in_dst_sel(in_dst_sel), .in_reg_write(in_reg_write),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off),
        .wb_valid(s_valid), .wb_we(s_we), .wb_addr(s_addr), .wb_data(s_data),
        .wb_misalign(s_misalign), .retired(s_retired)
    );

    typedef struct {
        logic        valid;
        logic        we;
        logic        mis;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] ret;
        logic [2:0]  ret_s;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   vectors     = 0;
    int   checks      = 0;
    int   miscompares = 0;

    task automatic applyStimulus(
        input logic r, s, f, v,
        input logic [1:0] wsel, dsel, input logic rw,
        input logic [1:0] lsz, input logic lu, input logic [1:0] off,
        input logic [31:0] alu, mem, pc4, input logic [4:0] rd, rt,
        input logic e_we, e_mis, input logic [4:0] e_addr, input logic [31:0] e_data);
        exp_t nxt;
        @(negedge clk);
        rst = r; stall = s; flush = f; in_valid = v;
        in_wb_sel = wsel; in_dst_sel = dsel; in_reg_write = rw;
        in_ld_size = lsz; in_ld_unsigned = lu; in_byte_off = off;
        in_alu = alu; in_mem = mem; in_pc4 = pc4; in_rd = rd; in_rt = rt;
        nxt.ret   = r ? 32'd0 : cur.ret + {31'd0, cur.valid};
        nxt.ret_s = r ? 3'd0 : cur.ret_s + {2'd0, cur.valid};
        nxt.valid = 1'b0;
        nxt.we    = 1'b0;
        nxt.mis   = 1'b0;
        nxt.addr  = 5'd0;
        nxt.data  = 32'd0;
        if (!r && !f && s) begin
            nxt.addr = cur.addr;
            nxt.data = cur.data;
        end else if (!r && !f) begin
            nxt.valid = v;
            nxt.we    = e_we;
            nxt.mis   = e_mis;
            nxt.addr  = e_addr;
            nxt.data  = e_data;
        end
        exp_q.push_back(nxt);
        cur = nxt;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu, input logic e_we);
        applyStimulus(0, 0, 0, 1, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00,
                      alu, 32'h0, 32'h0, rd, 5'd0, e_we, 0, rd, alu);
    endtask

    task automatic load_op(input logic [1:0] lsz, input logic lu, input logic [1:0] off,
                           input logic [31:0] mem, input logic [4:0] rt,
                           input logic e_we, e_mis, input logic [31:0] e_data);
        applyStimulus(0, 0, 0, 1, 2'b01, 2'b01, 1, lsz, lu, off,
                      32'h0, mem, 32'h0, 5'd0, rt, e_we, e_mis, rt, e_data);
    endtask

    // Control cycles carry a live-looking instruction so a wrongly accepted one shows up.
    task automatic ctrl(input logic r, s, f);
        applyStimulus(r, s, f, 1, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00,
                      32'h0BAD0BAD, 32'h0, 32'h0, 5'd9, 5'd0, 1, 0, 5'd9, 32'h0BAD0BAD);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00,
                      32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        cmp("wb_valid", {63'd0, wb_valid}, {63'd0, e.valid});
        cmp("wb_we", {63'd0, wb_we}, {63'd0, e.we});
        cmp("wb_misalign", {63'd0, wb_misalign}, {63'd0, e.mis});
        cmp("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
        cmp("wb_data", {32'd0, wb_data}, {32'd0, e.data});
        cmp("retired", {32'd0, retired}, {32'd0, e.ret});
        cmp("small_retired", {61'd0, s_retired}, {61'd0, e.ret_s});
        cmp("small_outputs", {24'd0, s_valid, s_we, s_misalign, s_addr, s_data},
            {24'd0, e.valid, e.we, e.mis, e.addr, e.data});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        cur = '{valid: 1'b0, we: 1'b0, mis: 1'b0, addr: 5'd0, data: 32'd0, ret: 32'd0, ret_s: 3'd0};
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_alu = '0; in_mem = '0; in_pc4 = '0; in_rd = '0; in_rt = '0;
        in_wb_sel = '0; in_dst_sel = '0; in_reg_write = 1'b0;
        in_ld_size = '0; in_ld_unsigned = 1'b0; in_byte_off = '0;

        ctrl(1, 0, 0);
        ctrl(1, 0, 0);
        alu_op(5'd5, 32'h1234ABCD, 1);
        idle();

        load_op(2'b10, 0, 2'b01, 32'h80FF7F01, 5'd8,  1, 0, 32'h0000007F);
        load_op(2'b10, 0, 2'b10, 32'h80FF7F01, 5'd9,  1, 0, 32'hFFFFFFFF);
        load_op(2'b10, 1, 2'b11, 32'h80FF7F01, 5'd10, 1, 0, 32'h00000080);
        load_op(2'b10, 0, 2'b11, 32'h80FF7F01, 5'd13, 1, 0, 32'hFFFFFF80);
        load_op(2'b10, 1, 2'b00, 32'h80FF7F01, 5'd14, 1, 0, 32'h00000001);
        load_op(2'b01, 0, 2'b10, 32'h80017FFE, 5'd11, 1, 0, 32'hFFFF8001);
        load_op(2'b01, 0, 2'b01, 32'h80017FFE, 5'd12, 0, 1, 32'h00007FFE);
        load_op(2'b01, 0, 2'b11, 32'h80017FFE, 5'd12, 0, 1, 32'h00007FFE);
        load_op(2'b01, 1, 2'b10, 32'h80017FFE, 5'd17, 1, 0, 32'h00008001);
        load_op(2'b01, 1, 2'b00, 32'h12348000, 5'd15, 1, 0, 32'h00008000);
        load_op(2'b01, 0, 2'b00, 32'h12348000, 5'd16, 1, 0, 32'hFFFF8000);
        load_op(2'b00, 0, 2'b10, 32'h80017FFE, 5'd18, 0, 1, 32'h80017FFE);
        load_op(2'b00, 0, 2'b00, 32'h80017FFE, 5'd18, 1, 0, 32'h80017FFE);
        load_op(2'b11, 0, 2'b01, 32'hA1B2C3D4, 5'd19, 0, 1, 32'hA1B2C3D4);
        load_op(2'b11, 1, 2'b00, 32'hA1B2C3D4, 5'd19, 1, 0, 32'hA1B2C3D4);
        applyStimulus(0, 0, 0, 0, 2'b01, 2'b01, 1, 2'b01, 0, 2'b01,
                      32'h0, 32'h0000ABCD, 32'h0, 5'd0, 5'd12, 0, 0, 5'd12, 32'hFFFFABCD);

        applyStimulus(0, 0, 0, 1, 2'b10, 2'b10, 1, 2'b00, 0, 2'b00,
                      32'h0, 32'h0, 32'h00400024, 5'd0, 5'd0, 1, 0, 5'd31, 32'h00400024);
        alu_op(5'd0, 32'hDEADBEEF, 0);
        applyStimulus(0, 0, 0, 1, 2'b00, 2'b11, 1, 2'b00, 0, 2'b00,
                      32'h55, 32'h0, 32'h0, 5'd7, 5'd7, 0, 0, 5'd0, 32'h55);
        applyStimulus(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b00, 0, 2'b00,
                      32'h1, 32'h0, 32'h0, 5'd3, 5'd0, 1, 0, 5'd3, 32'h0);
        applyStimulus(0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00,
                      32'h99, 32'h0, 32'h0, 5'd4, 5'd0, 0, 0, 5'd4, 32'h99);

        alu_op(5'd6, 32'hCAFEF00D, 1);
        ctrl(0, 1, 0);
        ctrl(0, 1, 0);
        ctrl(0, 1, 0);
        ctrl(0, 1, 1);
        alu_op(5'd20, 32'h00C0FFEE, 1);
        ctrl(0, 0, 1);
        idle();

        alu_op(5'd2, 32'hA5A5A5A5, 1);
        ctrl(1, 0, 0);
        idle();
        for (int i = 0; i < 10; i++) begin
            alu_op(5'(i + 1), 32'(i * 3 + 7), 1);
        end
        idle();
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage_p.md
Name: wb_stage_p

Overview:
Parametrised, registered MIPS write-back stage. It replaces the purely combinational result/destination muxing with a MEM/WB pipeline register, and adds:
- a link-register destination (JAL)
- a PC+4 result source
- sub-word load extraction with sign/zero extension
- stall/flush control and a retired-instruction counter

Sits between the memory stage and the register-file write port. Its registered outputs also serve as the WB-stage forwarding source.

Parameters:
DATA_W, 32, datapath width; must be >= 32; sub-word extraction uses bits [31:0].
REG_AW, 5, register-file address width.
LINK_REG, 31, destination address used for link writes.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold stage contents, accept nothing
flush  in  1  replace incoming instruction with bubble
in_valid  in  1  incoming instruction valid
in_alu  in  DATA_W  ALU result
in_mem  in  DATA_W  raw memory read word
in_pc4  in  DATA_W  return address (PC+4)
in_rd  in  REG_AW  rd field
in_rt  in  REG_AW  rt field
in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved
in_dst_sel  in  2  destination: 00 rd, 01 rt, 10 LINK_REG, 11 reserved
in_reg_write  in  1  instruction writes register file
in_ld_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
in_ld_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
in_byte_off  in  2  load address bits [1:0]
wb_valid  out  1  a valid instruction retired this cycle
wb_we  out  1  register-file write enable
wb_addr  out  REG_AW  register-file write address
wb_data  out  DATA_W  register-file write data
wb_misalign  out  1  misaligned load detected; write suppressed
retired  out  CNT_W  count of retired instructions

Behaviour:
Reset and latency:
- rst=1 at a clock edge: every output register, including retired, becomes 0. Reset mid-stream discards the in-flight instruction.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.

Per-edge priority: rst > flush > stall > normal.
- flush=1: capture a bubble. wb_valid=0, wb_we=0, wb_misalign=0; wb_addr and wb_data are don't-care, implement as 0. Flush wins over a simultaneous stall.
- stall=1 (no flush): wb_addr and wb_data hold their values; wb_valid, wb_we and wb_misalign go to 0. The held instruction therefore retires and writes exactly once.
- normal: capture the new instruction.
  - wb_valid = in_valid.
  - wb_we = in_valid & in_reg_write & ~reserved_dst & (addr != 0) & ~misalign.

Result mux:
- wb_sel 00 gives in_alu.
- 10 gives in_pc4.
- 11 gives 0.
- 01 gives the extracted load value, little-endian:
  - word: in_mem unchanged.
  - half: lane = in_mem[16*off[1] +: 16].
  - byte: lane = in_mem[8*off +: 8].
  - The lane is zero- or sign-extended to DATA_W.

Destination mux:
- dst_sel 00 gives in_rd, 01 gives in_rt, 10 gives LINK_REG.
- 11 gives address 0, and the write is suppressed.

Write/misalign rules:
- Address 0 never produces wb_we=1; wb_data is still driven.
- Misalign is a load (wb_sel=01) with either:
  - half size and off[0]=1, or
  - word size and off!=00.
- On misalign: wb_misalign=1 for one cycle, wb_we=0, wb_valid=1, and data is extracted as if off=00.
- wb_misalign only asserts when in_valid=1.

Retired counter:
- Increments by 1 on each edge where the registered wb_valid is 1, regardless of wb_we.
- Wraps modulo 2^CNT_W.
- Holds during stall and flush bubbles.

Test Plan:
- Reset, then in_valid=1, wb_sel=00, dst_sel=00, rd=5, alu=0x1234ABCD, reg_write=1 -> next cycle wb_we=1, wb_addr=5, wb_data=0x1234ABCD, wb_valid=1; retired=1 one cycle later.
- Load byte: mem=0x80FF7F01, off=01, signed -> wb_data=0xFFFFFF7F? No, byte1=0x7F -> 0x0000007F; off=10 signed -> 0xFFFFFFFF; off=11 unsigned -> 0x00000080.
- Load half: mem=0x8001_7FFE, off=10, signed -> wb_data=0xFFFF8001; off=01 -> wb_misalign=1, wb_we=0, wb_valid=1.
- JAL: wb_sel=10, dst_sel=10, pc4=0x00400024 -> wb_addr=31, wb_data=0x00400024, wb_we=1. Then dst_sel=00 with rd=0 -> wb_we=0.
- Stall for 3 cycles after a valid write -> wb_we asserted exactly once, wb_data/wb_addr held, retired increments once. Stall and flush in the same cycle -> bubble: wb_valid=0, wb_we=0.
- Preload a long instruction stream to reach retired=0xFFFFFFFF, one more retire -> retired=0. Assert rst mid-stream -> all outputs 0 the next cycle.
